// File: rtl/audio_pll_lock_ctrl.sv
// Audio PLL lock sequencer: reset pulse, lock wait, lock qualification, bounded retry and fault.
// Optional lock-loss event counter built when LOCK_LOSS_CNT_EN is defined.
module audio_pll_lock_ctrl #(
  parameter int unsigned RST_PULSE_CYCLES    = 16,
  parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 65536,
  parameter int unsigned MAX_RETRIES         = 3
) (
  input  logic       refclk,
  input  logic       rst_n,
  input  logic       pll_locked,
  input  logic       relock_req,
  output logic       pll_rst,
  output logic       audio_rst_n,
  output logic       ready,
  output logic       fault,
  output logic [3:0] retry_cnt,
  output logic [2:0] state_o,
  output logic [7:0] loss_cnt
);

  localparam int unsigned MAX_A = (RST_PULSE_CYCLES > LOCK_STABLE_CYCLES) ?
                                  RST_PULSE_CYCLES : LOCK_STABLE_CYCLES;
  localparam int unsigned MAX_P = (MAX_A > LOCK_TIMEOUT_CYCLES) ? MAX_A : LOCK_TIMEOUT_CYCLES;
  localparam int unsigned CNT_W = $clog2(MAX_P) + 1;

  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] STB_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [3:0]       RETRY_MAX = 4'(MAX_RETRIES);

  typedef enum logic [2:0] {
    S_RESET_PLL = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_RUN       = 3'd3,
    S_FAULT     = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       retry_q, retry_d;
  logic             sync1_q, lock_s_q;
  logic             pll_rst_q, pll_rst_d;
  logic             arst_n_q, arst_n_d;
  logic             ready_q, ready_d;
  logic             fault_q, fault_d;

  // NOTE: the reset branch lives inside the clocked block, so reset is sampled on refclk
  // like any other input; sequential state uses non-blocking assignments only.
  always_ff @(posedge refclk) begin
    if (!rst_n) begin
      sync1_q   <= 1'b0;
      lock_s_q  <= 1'b0;
      state_q   <= S_RESET_PLL;
      cnt_q     <= '0;
      retry_q   <= '0;
      pll_rst_q <= 1'b1;
      arst_n_q  <= 1'b0;
      ready_q   <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      sync1_q   <= pll_locked;
      lock_s_q  <= sync1_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      retry_q   <= retry_d;
      pll_rst_q <= pll_rst_d;
      arst_n_q  <= arst_n_d;
      ready_q   <= ready_d;
      fault_q   <= fault_d;
    end
  end

  // NOTE: every signal written here gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    retry_d = retry_q;

    unique case (state_q)
      S_RESET_PLL: begin
        if (cnt_q == RST_LAST) state_d = S_WAIT_LOCK;
      end
      S_WAIT_LOCK: begin
        if (lock_s_q) begin
          state_d = S_STABLE;
        end else if (cnt_q == TO_LAST) begin
          if (retry_q == RETRY_MAX) begin
            state_d = S_FAULT;
          end else begin
            retry_d = retry_q + 4'd1;
            state_d = S_RESET_PLL;
          end
        end
      end
      S_STABLE: begin
        // Any dropout restarts qualification with a fresh timeout window.
        if (!lock_s_q)             state_d = S_WAIT_LOCK;
        else if (cnt_q == STB_LAST) state_d = S_RUN;
      end
      S_RUN: begin
        if (!lock_s_q || relock_req) state_d = S_RESET_PLL;
      end
      S_FAULT: begin
        if (relock_req) begin
          retry_d = '0;
          state_d = S_RESET_PLL;
        end
      end
      default: state_d = S_RESET_PLL;
    endcase

    if (state_d == S_RUN && state_q != S_RUN) retry_d = '0;

    // Counter only times RESET_PLL / WAIT_LOCK / STABLE; it idles at zero elsewhere.
    if (state_d != state_q || state_q == S_RUN || state_q == S_FAULT) cnt_d = '0;
    else                                                              cnt_d = cnt_q + 1'b1;

    pll_rst_d = (state_d == S_RESET_PLL) || (state_d == S_FAULT);
    arst_n_d  = (state_d == S_RUN);
    ready_d   = (state_d == S_RUN);
    fault_d   = (state_d == S_FAULT);
  end

`ifdef LOCK_LOSS_CNT_EN
  logic [7:0] loss_q;

  always_ff @(posedge refclk) begin
    if (!rst_n) begin
      loss_q <= '0;
    end else if (state_q == S_RUN && !lock_s_q && loss_q != 8'hFF) begin
      loss_q <= loss_q + 8'd1;
    end
  end

  assign loss_cnt = loss_q;
`else
  assign loss_cnt = 8'd0;
`endif

  assign pll_rst     = pll_rst_q;
  assign audio_rst_n = arst_n_q;
  assign ready       = ready_q;
  assign fault       = fault_q;
  assign retry_cnt   = retry_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_audio_pll_lock_ctrl.sv
// Scoreboard bench for audio_pll_lock_ctrl with small timing parameters; expected outputs are
// queued as stimulus is applied and compared a cycle later, just after the active edge.
module tb_audio_pll_lock_ctrl;

  localparam int RST_P = 4;
  localparam int STB   = 8;
  localparam int TO    = 32;
  localparam int MAXR  = 2;
`ifdef LOCK_LOSS_CNT_EN
  localparam int LOSS_INC = 1;
`else
  localparam int LOSS_INC = 0;
`endif

  logic       refclk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pll_locked = 1'b0;
  logic       relock_req = 1'b0;
  logic       pll_rst, audio_rst_n, ready, fault;
  logic [3:0] retry_cnt;
  logic [2:0] state_o;
  logic [7:0] loss_cnt;

  always #5 refclk = ~refclk;

  audio_pll_lock_ctrl #(
    .RST_PULSE_CYCLES   (RST_P),
    .LOCK_STABLE_CYCLES (STB),
    .LOCK_TIMEOUT_CYCLES(TO),
    .MAX_RETRIES        (MAXR)
  ) dut (
    .refclk     (refclk),
    .rst_n      (rst_n),
    .pll_locked (pll_locked),
    .relock_req (relock_req),
    .pll_rst    (pll_rst),
    .audio_rst_n(audio_rst_n),
    .ready      (ready),
    .fault      (fault),
    .retry_cnt  (retry_cnt),
    .state_o    (state_o),
    .loss_cnt   (loss_cnt)
  );

  typedef struct packed {
    logic [2:0] st;
    logic       prst;
    logic       arst_n;
    logic       rdy;
    logic       flt;
    logic [3:0] retry;
    logic [7:0] loss;
  } outs_t;

  typedef struct {
    string tag;
    outs_t v;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   loss_exp = 0;

  // Output pattern implied by each state, plus the counters supplied by the caller.
  function automatic outs_t mk(input int st, input int retry, input int loss);
    outs_t o;
    o.st     = 3'(st);
    o.prst   = (st == 0) || (st == 4);
    o.arst_n = (st == 3);
    o.rdy    = (st == 3);
    o.flt    = (st == 4);
    o.retry  = 4'(retry);
    o.loss   = 8'(loss);
    return o;
  endfunction

  function automatic outs_t snap();
    return {state_o, pll_rst, audio_rst_n, ready, fault, retry_cnt, loss_cnt};
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge refclk);
    #1;
  endtask

  // Reset pulse with lock present; returns one edge after STABLE is entered (count 0).
  task automatic go_stable();
    rst_n = 1'b0; pll_locked = 1'b1; relock_req = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(5);
    loss_exp = 0;
  endtask

  task automatic test_reset();
    exp_t e; outs_t got;
    rst_n = 1'b0; pll_locked = 1'b0; relock_req = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      e.tag = $sformatf("reset_%0d", i); e.v = mk(0, 0, 0); sb_q.push_back(e);
      step(1);
      e = sb_q.pop_front(); got = snap(); n_cmp++;
      if (got !== e.v) begin n_bad++; $display("FAIL %s: got %h expected %h", e.tag, got, e.v); end
    end
  endtask

  task automatic test_nominal();
    exp_t e; outs_t got;
    rst_n = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      e.tag = $sformatf("nom_pulse_%0d", i); e.v = mk((i < 4) ? 0 : 1, 0, 0); sb_q.push_back(e);
      step(1);
      e = sb_q.pop_front(); got = snap(); n_cmp++;
      if (got !== e.v) begin n_bad++; $display("FAIL %s: got %h expected %h", e.tag, got, e.v); end
    end
    step(10);
    pll_locked = 1'b1;
    for (int i = 1; i <= 11; i++) begin
      e.tag = $sformatf("nom_lock_%0d", i);
      e.v = mk((i < 3) ? 1 : (i < 11) ? 2 : 3, 0, 0);
      sb_q.push_back(e);
      step(1);
      e = sb_q.pop_front(); got = snap(); n_cmp++;
      if (got !== e.v) begin n_bad++; $display("FAIL %s: got %h expected %h", e.tag, got, e.v); end
    end
  endtask

  task automatic test_relock_run();
    exp_t e; outs_t got;
    relock_req = 1'b1;
    for (int i = 1; i <= 14; i++) begin
      e.tag = $sformatf("relock_run_%0d", i);
      e.v = mk((i < 5) ? 0 : (i == 5) ? 1 : (i < 14) ? 2 : 3, 0, loss_exp);
      sb_q.push_back(e);
      step(1);
      relock_req = 1'b0;
      e = sb_q.pop_front(); got = snap(); n_cmp++;
      if (got !== e.v) begin n_bad++; $display("FAIL %s: got %h expected %h", e.tag, got, e.v); end
    end
  endtask

  task automatic test_glitch();
    exp_t e; outs_t got;
    go_stable();
    step(2);
    pll_locked = 1'b0;
    step(1);
    pll_locked = 1'b1;
    for (int i = 2; i <= 12; i++) begin
      e.tag = $sformatf("glitch_%0d", i);
      e.v = mk((i == 3) ? 1 : (i < 12) ? 2 : 3, 0, 0);
      sb_q.push_back(e);
      step(1);
      e = sb_q.pop_front(); got = snap(); n_cmp++;
      if (got !== e.v) begin n_bad++; $display("FAIL %s: got %h expected %h", e.tag, got, e.v); end
    end
  endtask

  task automatic test_loss();
    exp_t e; outs_t got;
    for (int rep = 1; rep <= 2; rep++) begin
      pll_locked = 1'b0;
      for (int i = 1; i <= 7; i++) begin
        if (i == 3) loss_exp = loss_exp + LOSS_INC;
        e.tag = $sformatf("loss%0d_%0d", rep, i);
        e.v = mk((i < 3) ? 3 : (i < 7) ? 0 : 1, 0, loss_exp);
        sb_q.push_back(e);
        step(1);
        e = sb_q.pop_front(); got = snap(); n_cmp++;
        if (got !== e.v) begin n_bad++; $display("FAIL %s: got %h expected %h", e.tag, got, e.v); end
      end
      pll_locked = 1'b1;
      e.tag = $sformatf("loss%0d_rerun", rep); e.v = mk(3, 0, loss_exp); sb_q.push_back(e);
      step(11);
      e = sb_q.pop_front(); got = snap(); n_cmp++;
      if (got !== e.v) begin n_bad++; $display("FAIL %s: got %h expected %h", e.tag, got, e.v); end
    end
  endtask

  task automatic test_reset_mid_stable();
    exp_t e; outs_t got;
    relock_req = 1'b1;
    step(1);
    relock_req = 1'b0;
    e.tag = "mid_stable_pre"; e.v = mk(2, 0, loss_exp); sb_q.push_back(e);
    step(6);
    e = sb_q.pop_front(); got = snap(); n_cmp++;
    if (got !== e.v) begin n_bad++; $display("FAIL %s: got %h expected %h", e.tag, got, e.v); end
    rst_n = 1'b0;
    loss_exp = 0;
    e.tag = "mid_stable_rst"; e.v = mk(0, 0, 0); sb_q.push_back(e);
    step(1);
    rst_n = 1'b1;
    e = sb_q.pop_front(); got = snap(); n_cmp++;
    if (got !== e.v) begin n_bad++; $display("FAIL %s: got %h expected %h", e.tag, got, e.v); end
  endtask

  // Each attempt spans RST_P + TO edges; the attempt after the last retry lands in FAULT.
  task automatic test_timeout();
    exp_t e; outs_t got;
    int   per, a, p;
    per = RST_P + TO;
    rst_n = 1'b0; pll_locked = 1'b0; relock_req = 1'b0;
    step(2);
    rst_n = 1'b1;
    for (int ed = 1; ed <= 3 * per + 4; ed++) begin
      relock_req = (ed == 10) || (ed == per + 2);
      a = ed / per;
      p = ed % per;
      e.tag = $sformatf("timeout_e%0d", ed);
      if (a > MAXR) e.v = mk(4, MAXR, 0);
      else          e.v = mk((p < RST_P) ? 0 : 1, a, 0);
      sb_q.push_back(e);
      step(1);
      e = sb_q.pop_front(); got = snap(); n_cmp++;
      if (got !== e.v) begin n_bad++; $display("FAIL %s: got %h expected %h", e.tag, got, e.v); end
    end
    relock_req = 1'b0;
  endtask

  task automatic test_recovery();
    exp_t e; outs_t got;
    relock_req = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      e.tag = $sformatf("recover_%0d", i); e.v = mk((i < 5) ? 0 : 1, 0, 0); sb_q.push_back(e);
      step(1);
      relock_req = 1'b0;
      e = sb_q.pop_front(); got = snap(); n_cmp++;
      if (got !== e.v) begin n_bad++; $display("FAIL %s: got %h expected %h", e.tag, got, e.v); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1);
  end

  initial begin
    step(1);
    test_reset();
    test_nominal();
    test_relock_run();
    test_glitch();
    test_loss();
    test_reset_mid_stable();
    test_timeout();
    test_recovery();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
